// File: rtl/el2_pkg.sv
// Shared EL2 types for the PMP CSR register file: configuration parameter, PMP entry
// encodings, CSR request opcodes and the CSR addresses of the PMP register banks.
package el2_pkg;

  typedef struct packed {
    logic [7:0] PMP_ENTRIES;
  } el2_param_t;

  localparam el2_param_t EL2_PARAM_DEFAULT = '{PMP_ENTRIES: 8'd16};

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } el2_pmp_mode_pkt_t;

  typedef struct packed {
    logic              lock;
    logic [1:0]        reserved;
    el2_pmp_mode_pkt_t mode;
    logic              execute;
    logic              write;
    logic              read;
  } el2_pmp_cfg_pkt_t;

  typedef enum logic [1:0] {
    EL2_CSR_READ  = 2'b00,
    EL2_CSR_WRITE = 2'b01,
    EL2_CSR_SET   = 2'b10,
    EL2_CSR_CLEAR = 2'b11
  } el2_pmp_csr_op_e;

  typedef enum logic {
    PMP_CSR_IDLE = 1'b0,
    PMP_CSR_RESP = 1'b1
  } el2_pmp_csr_state_e;

  localparam logic [11:0] EL2_CSR_PMPCFG0  = 12'h3A0;
  localparam logic [11:0] EL2_CSR_PMPADDR0 = 12'h3B0;

  function automatic logic [31:0] el2_pmp_csr_rmw(input el2_pmp_csr_op_e op,
                                                  input logic [31:0]     old_val,
                                                  input logic [31:0]     mask);
    case (op)
      EL2_CSR_WRITE: return mask;
      EL2_CSR_SET:   return old_val | mask;
      EL2_CSR_CLEAR: return old_val & ~mask;
      default:       return old_val;
    endcase
  endfunction

endpackage

// File: rtl/el2_pmp_cfg_legalize.sv
// Turns one proposed pmpcfg byte into the byte actually stored, given the byte
// currently held for that entry (locked entries keep their old value).
module el2_pmp_cfg_legalize
  import el2_pkg::*;
(
  input  logic [7:0] i_old_cfg,
  input  logic [7:0] i_new_cfg,
  output logic [7:0] o_cfg
);

  el2_pmp_cfg_pkt_t w_new;
  el2_pmp_cfg_pkt_t w_legal;

  always_comb begin
    w_new          = el2_pmp_cfg_pkt_t'(i_new_cfg);
    w_legal        = w_new;
    w_legal.reserved = 2'b00;
    // W without R is not a legal combination, so the write permission is dropped
    w_legal.write  = w_new.write & w_new.read;
    if (i_old_cfg[7]) begin
      w_legal = el2_pmp_cfg_pkt_t'(i_old_cfg);
    end
  end

  assign o_cfg = w_legal;

endmodule

// File: rtl/el2_pmp_csr_regs.sv
// Machine-mode PMP CSR register file: one outstanding CSR access at a time, WARL and
// lock rules on pmpcfgN/pmpaddrN, decoded entry arrays for the PMP checker.
module el2_pmp_csr_regs
  import el2_pkg::*;
#(
  parameter el2_param_t pt = EL2_PARAM_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             csr_req_valid,
  output logic             csr_req_ready,
  input  el2_pmp_csr_op_e  csr_req_op,
  input  logic [11:0]      csr_req_addr,
  input  logic [31:0]      csr_req_wdata,
  output logic             csr_rsp_valid,
  input  logic             csr_rsp_ready,
  output logic [31:0]      csr_rsp_rdata,
  output logic             csr_rsp_err,
  output el2_pmp_cfg_pkt_t pmp_pmpcfg  [(pt.PMP_ENTRIES == 8'd0) ? 1 : int'(pt.PMP_ENTRIES)],
  output logic [31:0]      pmp_pmpaddr [(pt.PMP_ENTRIES == 8'd0) ? 1 : int'(pt.PMP_ENTRIES)]
);

  localparam int NENT = int'(pt.PMP_ENTRIES);
  // A zero-entry build keeps one never-written element per array
  localparam int NARR = (NENT == 0) ? 1 : NENT;
  localparam int NCFG = NENT / 4;

  el2_pmp_csr_state_e r_state;
  el2_pmp_csr_state_e w_state_next;
  el2_pmp_cfg_pkt_t   r_cfg  [NARR];
  logic [31:0]        r_addr [NARR];
  logic [31:0]        r_rdata;
  logic               r_err;

  logic [11:0]     w_cfg_off;
  logic [11:0]     w_addr_off;
  logic            w_is_cfg;
  logic            w_is_addr;
  logic            w_err;
  logic            w_accept;
  logic            w_do_write;
  logic            w_cfg_we;
  logic            w_addr_we;
  logic [31:0]     w_old_cfg_word;
  logic [31:0]     w_old_addr;
  logic [31:0]     w_old_word;
  logic [31:0]     w_new_word;
  logic [31:0]     w_cfg_legal;
  logic [NARR-1:0] w_addr_locked;
  logic            w_addr_locked_sel;

  // Address decode
  assign w_cfg_off  = csr_req_addr - EL2_CSR_PMPCFG0;
  assign w_addr_off = csr_req_addr - EL2_CSR_PMPADDR0;
  assign w_is_cfg   = (csr_req_addr >= EL2_CSR_PMPCFG0) && (32'(w_cfg_off) < 32'(NCFG));
  assign w_is_addr  = (csr_req_addr >= EL2_CSR_PMPADDR0) && (32'(w_addr_off) < 32'(NENT));
  assign w_err      = ~(w_is_cfg | w_is_addr);

  // An address register is frozen by its own lock or by a locked TOR entry above it
  if (NENT == 0) begin : g_no_entries
    assign w_addr_locked = '0;
  end else begin : g_entries
    for (genvar gi = 0; gi < NENT; gi++) begin : g_addr_lock
      if (gi + 1 < NENT) begin : g_tor
        assign w_addr_locked[gi] = r_cfg[gi].lock |
                                   (r_cfg[gi+1].lock & (r_cfg[gi+1].mode == TOR));
      end else begin : g_last
        assign w_addr_locked[gi] = r_cfg[gi].lock;
      end
    end
  end

  always_comb begin
    w_old_cfg_word    = '0;
    w_old_addr        = '0;
    w_addr_locked_sel = 1'b0;
    for (int e = 0; e < NENT; e++) begin
      if (32'(e / 4) == 32'(w_cfg_off)) begin
        w_old_cfg_word[8*(e%4) +: 8] = r_cfg[e];
      end
      if (32'(e) == 32'(w_addr_off)) begin
        w_old_addr        = r_addr[e];
        w_addr_locked_sel = w_addr_locked[e];
      end
    end
  end

  assign w_old_word = w_is_cfg ? w_old_cfg_word : w_old_addr;
  assign w_new_word = el2_pmp_csr_rmw(csr_req_op, w_old_word, csr_req_wdata);

  for (genvar gi = 0; gi < 4; gi++) begin : g_legal
    el2_pmp_cfg_legalize u_legal (
      .i_old_cfg (w_old_cfg_word[8*gi +: 8]),
      .i_new_cfg (w_new_word[8*gi +: 8]),
      .o_cfg     (w_cfg_legal[8*gi +: 8])
    );
  end

  assign w_accept   = csr_req_valid & csr_req_ready;
  assign w_do_write = w_accept & (csr_req_op != EL2_CSR_READ);
  assign w_cfg_we   = w_do_write & w_is_cfg;
  assign w_addr_we  = w_do_write & w_is_addr & ~w_addr_locked_sel;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int e = 0; e < NARR; e++) begin
        r_cfg[e]  <= '0;
        r_addr[e] <= '0;
      end
    end else begin
      for (int e = 0; e < NENT; e++) begin
        if (w_cfg_we && (32'(e / 4) == 32'(w_cfg_off))) begin
          r_cfg[e] <= el2_pmp_cfg_pkt_t'(w_cfg_legal[8*(e%4) +: 8]);
        end
        if (w_addr_we && (32'(e) == 32'(w_addr_off))) begin
          r_addr[e] <= w_new_word;
        end
      end
    end
  end

  // Response payload is captured at accept and held until the requester consumes it
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= w_err ? 32'h0 : w_old_word;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= PMP_CSR_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    csr_req_ready = 1'b0;
    csr_rsp_valid = 1'b0;
    case (r_state)
      PMP_CSR_IDLE: begin
        csr_req_ready = 1'b1;
        if (csr_req_valid) begin
          w_state_next = PMP_CSR_RESP;
        end
      end
      PMP_CSR_RESP: begin
        csr_rsp_valid = 1'b1;
        if (csr_rsp_ready) begin
          w_state_next = PMP_CSR_IDLE;
        end
      end
      default: w_state_next = PMP_CSR_IDLE;
    endcase
  end

  assign csr_rsp_rdata = r_rdata;
  assign csr_rsp_err   = r_err;

  for (genvar gi = 0; gi < NARR; gi++) begin : g_out
    assign pmp_pmpcfg[gi]  = r_cfg[gi];
    assign pmp_pmpaddr[gi] = r_addr[gi];
  end

endmodule

// File: tb/tb_el2_pmp_csr_regs.sv
// Bench for el2_pmp_csr_regs: directed vector table, hand-built handshake/reset
// sequences, and random accesses checked against a byte/word-level reference model.
module tb_el2_pmp_csr_regs;
  import el2_pkg::*;

  localparam int N = 16;

  logic             clk = 1'b0;
  logic             rst_l;
  logic             csr_req_valid;
  logic             csr_req_ready;
  el2_pmp_csr_op_e  csr_req_op;
  logic [11:0]      csr_req_addr;
  logic [31:0]      csr_req_wdata;
  logic             csr_rsp_valid;
  logic             csr_rsp_ready;
  logic [31:0]      csr_rsp_rdata;
  logic             csr_rsp_err;
  el2_pmp_cfg_pkt_t pmp_pmpcfg  [N];
  logic [31:0]      pmp_pmpaddr [N];

  el2_pmp_csr_regs dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .csr_req_valid (csr_req_valid),
    .csr_req_ready (csr_req_ready),
    .csr_req_op    (csr_req_op),
    .csr_req_addr  (csr_req_addr),
    .csr_req_wdata (csr_req_wdata),
    .csr_rsp_valid (csr_rsp_valid),
    .csr_rsp_ready (csr_rsp_ready),
    .csr_rsp_rdata (csr_rsp_rdata),
    .csr_rsp_err   (csr_rsp_err),
    .pmp_pmpcfg    (pmp_pmpcfg),
    .pmp_pmpaddr   (pmp_pmpaddr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: raw cfg bytes per entry and pmpaddr words
  logic [7:0]  m_cfg  [N];
  logic [31:0] m_addr [N];

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int e = 0; e < N; e++) begin
      m_cfg[e]  = 8'h00;
      m_addr[e] = 32'h0;
    end
  endtask

  function automatic logic [31:0] apply_op(input logic [1:0] op, input logic [31:0] old,
                                           input logic [31:0] wd);
    if (op == 2'd1) return wd;
    if (op == 2'd2) return old | wd;
    if (op == 2'd3) return old & ~wd;
    return old;
  endfunction

  task automatic model_access(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    logic [31:0] old;
    logic [31:0] nv;
    logic [7:0]  b;
    logic        lk;
    int          n;
    rd = 32'h0;
    er = 1'b0;
    if (addr >= 12'h3A0 && addr <= 12'h3A3) begin
      n   = int'(addr - 12'h3A0);
      old = {m_cfg[4*n+3], m_cfg[4*n+2], m_cfg[4*n+1], m_cfg[4*n]};
      rd  = old;
      nv  = apply_op(op, old, wd);
      if (op != 2'd0) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_cfg[4*n+k][7]) begin
            b = nv[8*k +: 8];
            b[6:5] = 2'b00;
            if (b[1:0] == 2'b10) b[1] = 1'b0;
            m_cfg[4*n+k] = b;
          end
        end
      end
    end else if (addr >= 12'h3B0 && addr <= 12'h3BF) begin
      n   = int'(addr - 12'h3B0);
      old = m_addr[n];
      rd  = old;
      lk  = m_cfg[n][7];
      if (n < N - 1) lk = lk | (m_cfg[n+1][7] & (m_cfg[n+1][4:3] == 2'b01));
      if (op != 2'd0 && !lk) m_addr[n] = apply_op(op, old, wd);
    end else begin
      er = 1'b1;
    end
  endtask

  task automatic compare_state(input string tag);
    int         diffs;
    logic [7:0] b;
    diffs = 0;
    for (int e = 0; e < N; e++) begin
      b = pmp_pmpcfg[e];
      if (b !== m_cfg[e] || pmp_pmpaddr[e] !== m_addr[e]) diffs++;
    end
    check({tag, "_state_diffs"}, 32'(diffs), 32'h0);
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // The reference model must already reflect this access when called.
  task automatic xact(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      input string tag, output logic [31:0] rd, output logic er);
    int n;
    csr_req_valid = 1'b1;
    csr_req_op    = el2_pmp_csr_op_e'(op);
    csr_req_addr  = addr;
    csr_req_wdata = wd;
    n = 0;
    while (!csr_req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_ready"}, 32'(csr_req_ready), 32'h1);
    @(negedge clk);
    csr_req_valid = 1'b0;
    check({tag, "_rsp_valid_t1"}, 32'(csr_rsp_valid), 32'h1);
    compare_state(tag);
    n = 0;
    while (!csr_rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    rd = csr_rsp_rdata;
    er = csr_rsp_err;
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    check({tag, "_rsp_done"}, 32'(csr_rsp_valid), 32'h0);
    $display("xact %s op=%0d addr=%03h wdata=%08h -> rdata=%08h err=%0d",
             tag, op, addr, wd, rd, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [23];
    logic [31:0] rd;
    logic        er;
    logic [31:0] e_rd;
    logic        e_er;
    logic [11:0] illegal [7];
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wd;
    int          sel;

    vecs[0]  = '{2'd0, 12'h3A0, 32'h0,         32'h0,         1'b0, "rd_cfg0_rst"};
    vecs[1]  = '{2'd0, 12'h3B5, 32'h0,         32'h0,         1'b0, "rd_addr5_rst"};
    vecs[2]  = '{2'd1, 12'h3A0, 32'h9F0F_6B1A, 32'h0,         1'b0, "wr_cfg0"};
    vecs[3]  = '{2'd0, 12'h3A0, 32'h0,         32'h9F0F_0B18, 1'b0, "rd_cfg0_legal"};
    vecs[4]  = '{2'd1, 12'h3A0, 32'h0,         32'h9F0F_0B18, 1'b0, "wr_cfg0_zero"};
    vecs[5]  = '{2'd0, 12'h3A0, 32'h0,         32'h9F00_0000, 1'b0, "rd_cfg0_lock3"};
    vecs[6]  = '{2'd1, 12'h3B3, 32'h0000_1234, 32'h0,         1'b0, "wr_addr3_locked"};
    vecs[7]  = '{2'd0, 12'h3B3, 32'h0,         32'h0,         1'b0, "rd_addr3"};
    vecs[8]  = '{2'd2, 12'h3A0, 32'h0000_8F00, 32'h9F00_0000, 1'b0, "set_cfg0_b1"};
    vecs[9]  = '{2'd0, 12'h3A0, 32'h0,         32'h9F00_8F00, 1'b0, "rd_cfg0_tor"};
    vecs[10] = '{2'd1, 12'h3B0, 32'h0000_DEAD, 32'h0,         1'b0, "wr_addr0_tor"};
    vecs[11] = '{2'd0, 12'h3B0, 32'h0,         32'h0,         1'b0, "rd_addr0"};
    vecs[12] = '{2'd1, 12'h3B2, 32'h0000_0055, 32'h0,         1'b0, "wr_addr2"};
    vecs[13] = '{2'd0, 12'h3B2, 32'h0,         32'h0000_0055, 1'b0, "rd_addr2"};
    vecs[14] = '{2'd1, 12'h3B4, 32'h0000_000F, 32'h0,         1'b0, "wr_addr4"};
    vecs[15] = '{2'd2, 12'h3B4, 32'h0000_00F0, 32'h0000_000F, 1'b0, "set_addr4"};
    vecs[16] = '{2'd3, 12'h3B4, 32'h0000_0003, 32'h0000_00FF, 1'b0, "clr_addr4"};
    vecs[17] = '{2'd2, 12'h3B4, 32'h0,         32'h0000_00FC, 1'b0, "set_addr4_m0"};
    vecs[18] = '{2'd0, 12'h3B4, 32'h0,         32'h0000_00FC, 1'b0, "rd_addr4"};
    vecs[19] = '{2'd0, 12'h3C0, 32'h0,         32'h0,         1'b1, "rd_3c0_err"};
    vecs[20] = '{2'd1, 12'h3A4, 32'hFFFF_FFFF, 32'h0,         1'b1, "wr_3a4_err"};
    vecs[21] = '{2'd0, 12'h3BF, 32'h0,         32'h0,         1'b0, "rd_addr15"};
    vecs[22] = '{2'd0, 12'h3A3, 32'h0,         32'h0,         1'b0, "rd_cfg3"};

    illegal[0] = 12'h3A4; illegal[1] = 12'h3AF; illegal[2] = 12'h3C0; illegal[3] = 12'h39F;
    illegal[4] = 12'h000; illegal[5] = 12'h7B0; illegal[6] = 12'hFFF;

    rst_l = 1'b0;
    csr_req_valid = 1'b0;
    csr_req_op    = EL2_CSR_READ;
    csr_req_addr  = '0;
    csr_req_wdata = '0;
    csr_rsp_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    check("rst_req_ready", 32'(csr_req_ready), 32'h1);
    check("rst_rsp_valid", 32'(csr_rsp_valid), 32'h0);
    check("rst_rdata", csr_rsp_rdata, 32'h0);
    check("rst_err", 32'(csr_rsp_err), 32'h0);
    compare_state("rst");

    for (int i = 0; i < 23; i++) begin
      model_access(vecs[i].op, vecs[i].addr, vecs[i].wdata, e_rd, e_er);
      xact(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].name, rd, er);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
      if (i == 2) begin
        check("e0_mode_napot", 32'(pmp_pmpcfg[0].mode), 32'(NAPOT));
        check("e0_write_fix", 32'(pmp_pmpcfg[0].write), 32'h0);
        check("e1_reserved", 32'(pmp_pmpcfg[1].reserved), 32'h0);
        check("e3_lock", 32'(pmp_pmpcfg[3].lock), 32'h1);
      end
    end

    // Response held off for three cycles while a second request waits unsampled
    model_access(2'd0, 12'h3C0, 32'h0, e_rd, e_er);
    csr_req_valid = 1'b1;
    csr_req_op    = EL2_CSR_READ;
    csr_req_addr  = 12'h3C0;
    csr_req_wdata = 32'h0;
    @(negedge clk);
    csr_req_op    = EL2_CSR_WRITE;
    csr_req_addr  = 12'h3B6;
    csr_req_wdata = 32'h0000_0077;
    for (int c = 0; c < 3; c++) begin
      check("hold_rsp_valid", 32'(csr_rsp_valid), 32'h1);
      check("hold_rdata", csr_rsp_rdata, e_rd);
      check("hold_err", 32'(csr_rsp_err), 32'(e_er));
      check("hold_req_ready", 32'(csr_req_ready), 32'h0);
      compare_state("hold");
      @(negedge clk);
    end
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;
    check("free_req_ready", 32'(csr_req_ready), 32'h1);
    check("free_rsp_valid", 32'(csr_rsp_valid), 32'h0);
    model_access(2'd1, 12'h3B6, 32'h0000_0077, e_rd, e_er);
    @(negedge clk);
    csr_req_valid = 1'b0;
    check("held_rsp_valid", 32'(csr_rsp_valid), 32'h1);
    check("held_rdata", csr_rsp_rdata, e_rd);
    check("held_err", 32'(csr_rsp_err), 32'(e_er));
    compare_state("held");
    $display("xact held op=1 addr=3b6 wdata=00000077 -> rdata=%08h err=%0d",
             csr_rsp_rdata, csr_rsp_err);
    csr_rsp_ready = 1'b1;
    @(negedge clk);
    csr_rsp_ready = 1'b0;

    for (int t = 0; t < 250; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 2)      addr = 12'h3A0 + 12'($urandom_range(0, 3));
      else if (sel <= 7) addr = 12'h3B0 + 12'($urandom_range(0, 15));
      else if (sel == 8) addr = illegal[$urandom_range(0, 6)];
      else               addr = 12'($urandom);
      op = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (sel <= 2 && $urandom_range(0, 7) != 0) wd = wd & 32'h7F7F_7F7F;
      model_access(op, addr, wd, e_rd, e_er);
      xact(op, addr, wd, "rnd", rd, er);
      check("rnd_rdata", rd, e_rd);
      check("rnd_err", 32'(er), 32'(e_er));
    end

    // Reset pulled while a response is pending
    csr_req_valid = 1'b1;
    csr_req_op    = EL2_CSR_WRITE;
    csr_req_addr  = 12'h3B7;
    csr_req_wdata = 32'h0000_ABCD;
    @(negedge clk);
    csr_req_valid = 1'b0;
    check("pre_rst_rsp_valid", 32'(csr_rsp_valid), 32'h1);
    #2;
    rst_l = 1'b0;
    #1;
    model_reset();
    check("mid_rst_rsp_valid", 32'(csr_rsp_valid), 32'h0);
    check("mid_rst_req_ready", 32'(csr_req_ready), 32'h1);
    check("mid_rst_rdata", csr_rsp_rdata, 32'h0);
    compare_state("mid_rst");
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    model_access(2'd0, 12'h3A0, 32'h0, e_rd, e_er);
    xact(2'd0, 12'h3A0, 32'h0, "post_rst_rd", rd, er);
    check("post_rst_rd_rdata", rd, 32'h0);
    model_access(2'd1, 12'h3A0, 32'h8000_0001, e_rd, e_er);
    xact(2'd1, 12'h3A0, 32'h8000_0001, "post_rst_wr", rd, er);
    model_access(2'd0, 12'h3A0, 32'h0, e_rd, e_er);
    xact(2'd0, 12'h3A0, 32'h0, "post_rst_rd2", rd, er);
    check("post_rst_unlocked", rd, 32'h8000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
